// File: rtl/scope_capture_ctrl_if.sv
// Sample-RAM write port driven by the scope capture controller.
interface scope_capture_ctrl_if #(
  parameter int NSIG = 1,
  parameter int AW   = 10
);
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [NSIG-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/scope_capture_ctrl.sv
// Scope capture sequencer: arm -> pre-trigger fill -> wait for trigger -> post-trigger fill -> done,
// writing decimated trigger-stage samples into a circular sample RAM.
module scope_capture_ctrl #(
  parameter int NSIG = 1,
  parameter int AW   = 10,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSIG-1:0]      sig,
  input  logic                 triggered,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 force_trig,
  input  logic [AW-1:0]        npre,
  input  logic [AW-1:0]        npost,
  input  logic [DW-1:0]        div,
  scope_capture_ctrl_if.master ram,
  output logic [AW-1:0]        trig_addr,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;

  logic [DW-1:0]   div_q, div_d;
  logic [DW-1:0]   presc_q, presc_d;
  logic [AW-1:0]   npre_q, npre_d;
  logic [AW-1:0]   npost_q, npost_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   cnt_inc;
  logic [AW-1:0]   trig_addr_q, trig_addr_d;

  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [NSIG-1:0] wr_data_q, wr_data_d;

  logic            active;
  logic            stb;
  logic            trig;

  assign active  = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
  assign stb     = active && (presc_q == '0);
  assign trig    = triggered | force_trig;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    npre_d      = npre_q;
    npost_d     = npost_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    presc_d     = presc_q;

    if (active) begin
      presc_d = (presc_q == div_q) ? '0 : presc_q + 1'b1;
    end

    // Abort outranks everything, including an arm or a strobe write in the same cycle.
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d     = (npre == '0) ? WAIT : PRE;
            ptr_d       = '0;
            cnt_d       = '0;
            presc_d     = '0;
            npre_d      = npre;
            npost_d     = npost;
            div_d       = div;
            trig_addr_d = '0;
          end
        end

        PRE, WAIT, POST: begin
          if (stb) begin
            wr_en_d   = 1'b1;
            wr_data_d = sig;
            wr_addr_d = ptr_q;
            ptr_d     = ptr_q + 1'b1;

            if (state_q == PRE) begin
              cnt_d = cnt_inc;
              if (cnt_inc == npre_q) begin
                state_d = WAIT;
                cnt_d   = '0;
              end
            end else if (state_q == WAIT) begin
              if (trig) begin
                trig_addr_d = ptr_q;
                cnt_d       = '0;
                state_d     = (npost_q == '0) ? DONE : POST;
              end
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == npost_q) begin
                state_d = DONE;
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      presc_q     <= '0;
      npre_q      <= '0;
      npost_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      div_q       <= div_d;
      presc_q     <= presc_d;
      npre_q      <= npre_d;
      npost_q     <= npost_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign ram.wr_en   = wr_en_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.wr_data = wr_data_q;
  assign trig_addr   = trig_addr_q;
  assign busy        = active;
  assign done        = (state_q == DONE);
  assign state       = state_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl: a table of captures plus hand-written abort/reset sequences.
module tb_scope_capture_ctrl;

  typedef struct {
    logic [9:0] addr;
    logic       data;
    bit         last;
    int         cyc;
  } wr_t;

  typedef struct {
    int sel;
    int dv;
    int npre;
    int npost;
    int trig_k;
    bit force_t;
    bit hold;
    int exp_writes;
    int exp_trig;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:0]  sig = '0;
  logic        triggered = 1'b0;
  logic        arm_a = 1'b0;
  logic        arm_b = 1'b0;
  logic        abort = 1'b0;
  logic        force_trig = 1'b0;
  logic [9:0]  npre = '0;
  logic [9:0]  npost = '0;
  logic [15:0] div = '0;

  logic [9:0]  trig_a;
  logic        busy_a, done_a;
  logic [2:0]  state_a;
  logic [2:0]  trig_b;
  logic        busy_b, done_b;
  logic [2:0]  state_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int wr_cnt0  = 0;
  int wr_cnt1  = 0;
  wr_t exp_q0[$];
  wr_t exp_q1[$];
  wr_t e_mon;
  vec_t vecs[6];

  scope_capture_ctrl_if #(.NSIG(1), .AW(10)) ram_a ();
  scope_capture_ctrl_if #(.NSIG(1), .AW(3))  ram_b ();

  scope_capture_ctrl #(.NSIG(1), .AW(10), .DW(16)) dut_a (
    .clk(clk), .reset(reset), .sig(sig), .triggered(triggered), .arm(arm_a),
    .abort(abort), .force_trig(force_trig), .npre(npre), .npost(npost), .div(div),
    .ram(ram_a), .trig_addr(trig_a), .busy(busy_a), .done(done_a), .state(state_a)
  );

  scope_capture_ctrl #(.NSIG(1), .AW(3), .DW(16)) dut_b (
    .clk(clk), .reset(reset), .sig(sig), .triggered(triggered), .arm(arm_b),
    .abort(abort), .force_trig(force_trig), .npre(npre[2:0]), .npost(npost[2:0]), .div(div),
    .ram(ram_b), .trig_addr(trig_b), .busy(busy_b), .done(done_b), .state(state_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Each write must land on the exact cycle, address and data predicted when its strobe was driven.
  always @(negedge clk) begin
    if (ram_a.wr_en) begin
      wr_cnt0++;
      check("wr_a_expected", 32'(exp_q0.size() != 0), 32'd1);
      if (exp_q0.size() != 0) begin
        e_mon = exp_q0.pop_front();
        check("wr_a_cycle", 32'(cyc_n), 32'(e_mon.cyc));
        check("wr_a_addr", 32'(ram_a.wr_addr), 32'(e_mon.addr));
        check("wr_a_data", 32'(ram_a.wr_data), 32'(e_mon.data));
        check("wr_a_done", 32'(done_a), 32'(e_mon.last));
        check("wr_a_busy", 32'(busy_a), 32'(!e_mon.last));
      end
    end
    if (ram_b.wr_en) begin
      wr_cnt1++;
      check("wr_b_expected", 32'(exp_q1.size() != 0), 32'd1);
      if (exp_q1.size() != 0) begin
        e_mon = exp_q1.pop_front();
        check("wr_b_cycle", 32'(cyc_n), 32'(e_mon.cyc));
        check("wr_b_addr", 32'(ram_b.wr_addr), 32'(e_mon.addr));
        check("wr_b_data", 32'(ram_b.wr_data), 32'(e_mon.data));
        check("wr_b_done", 32'(done_b), 32'(e_mon.last));
        check("wr_b_busy", 32'(busy_b), 32'(!e_mon.last));
      end
    end
  end

  task automatic push_wr(input int sel, input int k, input bit last);
    wr_t w;
    w.addr = (sel != 0) ? 10'(k % 8) : 10'(k % 1024);
    w.data = sig[0];
    w.last = last;
    w.cyc  = cyc_n + 1;
    if (sel != 0) exp_q1.push_back(w);
    else          exp_q0.push_back(w);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sig = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  period, n, budget, k;
    bit  is_stb, got_done;
    period   = v.dv + 1;
    n        = v.trig_k + 1 + v.npost;
    budget   = (n + 4) * period + 20;
    got_done = 1'b0;
    wr_cnt0  = 0;
    wr_cnt1  = 0;

    @(posedge clk); #1;
    npre       = 10'(v.npre);
    npost      = 10'(v.npost);
    div        = 16'(v.dv);
    force_trig = v.force_t;
    triggered  = v.hold;
    if (v.sel != 0) arm_b = 1'b1;
    else            arm_a = 1'b1;

    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      arm_a  = 1'b0;
      arm_b  = 1'b0;
      sig    = 1'($urandom_range(0, 1));
      is_stb = ((c - 1) % period) == 0;
      k      = (c - 1) / period;
      // Pulsed triggers also hit a PRE strobe and a between-strobe WAIT cycle; both must be ignored.
      if (!v.hold)
        triggered = (is_stb && (k == v.trig_k || (k == 0 && v.npre > 0))) ||
                    (!is_stb && v.dv > 0 && k == v.trig_k - 1 && k >= v.npre);
      if (is_stb && k < n) push_wr(v.sel, k, k == n - 1);
      @(negedge clk);
      if ((v.sel != 0) ? done_b : done_a) begin
        got_done = 1'b1;
        break;
      end
    end
    #1;
    triggered  = 1'b0;
    force_trig = 1'b0;

    check($sformatf("v%0d_done_reached", idx), 32'(got_done), 32'd1);
    check($sformatf("v%0d_busy", idx), (v.sel != 0) ? 32'(busy_b) : 32'(busy_a), 32'd0);
    check($sformatf("v%0d_state", idx), (v.sel != 0) ? 32'(state_b) : 32'(state_a), 32'd4);
    check($sformatf("v%0d_trig_addr", idx), (v.sel != 0) ? 32'(trig_b) : 32'(trig_a), 32'(v.exp_trig));
    check($sformatf("v%0d_writes", idx), (v.sel != 0) ? 32'(wr_cnt1) : 32'(wr_cnt0), 32'(v.exp_writes));
    check($sformatf("v%0d_pending", idx), (v.sel != 0) ? 32'(exp_q1.size()) : 32'(exp_q0.size()), 32'd0);
    idle_cycles(3);
    check($sformatf("v%0d_done_hold", idx), (v.sel != 0) ? 32'(done_b) : 32'(done_a), 32'd1);
  endtask

  initial begin
    //          sel div npre npost trig_k force hold writes trig
    vecs[0] = '{0,  0,  4,   3,    6,     0,    0,   10,    6};
    vecs[1] = '{0,  0,  2,   2,    2,     0,    1,   5,     2};
    vecs[2] = '{0,  2,  1,   1,    1,     1,    0,   3,     1};
    vecs[3] = '{0,  0,  0,   0,    0,     1,    0,   1,     0};
    vecs[4] = '{1,  0,  0,   0,    10,    0,    0,   11,    2};
    vecs[5] = '{0,  3,  3,   2,    5,     0,    0,   8,     5};

    #2;
    check("rst_state_a", 32'(state_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_wr_en_a", 32'(ram_a.wr_en), 32'd0);
    check("rst_wr_addr_a", 32'(ram_a.wr_addr), 32'd0);
    check("rst_wr_data_a", 32'(ram_a.wr_data), 32'd0);
    check("rst_trig_a", 32'(trig_a), 32'd0);
    check("rst_state_b", 32'(state_b), 32'd0);
    check("rst_wr_en_b", 32'(ram_b.wr_en), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Abort in POST: npre=2, forced trigger at addr 2, abort on the fifth strobe cycle.
    @(posedge clk); #1;
    npre = 10'd2; npost = 10'd5; div = '0; force_trig = 1'b1; arm_a = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      arm_a = 1'b0;
      sig   = 1'($urandom_range(0, 1));
      push_wr(0, c - 1, 1'b0);
    end
    @(posedge clk); #1;
    sig = 1'($urandom_range(0, 1));
    check("abort_pre_state", 32'(state_a), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b0;
    force_trig = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(state_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_trig_kept", 32'(trig_a), 32'd2);
    idle_cycles(4);
    check("abort_pending", 32'(exp_q0.size()), 32'd0);

    // Arm and abort together from IDLE.
    @(posedge clk); #1;
    npre = 10'd1; npost = 10'd1; arm_a = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    arm_a = 1'b0; abort = 1'b0;
    check("arm_abort_state", 32'(state_a), 32'd0);
    check("arm_abort_busy", 32'(busy_a), 32'd0);
    idle_cycles(3);
    check("arm_abort_state_hold", 32'(state_a), 32'd0);

    // Asynchronous reset while in WAIT, between clock edges.
    @(posedge clk); #1;
    npre = 10'd1; npost = 10'd2; div = '0; arm_a = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      arm_a = 1'b0;
      sig   = 1'($urandom_range(0, 1));
      push_wr(0, c - 1, 1'b0);
    end
    check("mid_rst_pre_state", 32'(state_a), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    exp_q0.delete();
    check("mid_rst_state", 32'(state_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_wr_en", 32'(ram_a.wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(ram_a.wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(ram_a.wr_data), 32'd0);
    check("mid_rst_trig", 32'(trig_a), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2);
    run_vec(6, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scope_capture_ctrl.md
# scope_capture_ctrl

Sequencing controller for the logic-analyser scope capture path. It takes the per-cycle `sigout`/`triggered` outputs of the level/edge trigger stage, optionally decimates them, and writes samples into an external circular sample RAM. Writing follows an arm → pre-trigger fill → wait-for-trigger → post-trigger fill → done sequence. It sits between the trigger stage and the sample RAM, and is controlled and read back by the host register interface.

## Interface

- `NSIG`, 1: sample width; must match the trigger stage.
- `AW`, 10: sample RAM address width; depth is 2^AW.
- `DW`, 16: decimation divider width.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; forces every register to its reset value.
- `sig` in NSIG: sample data (trigger stage `sigout`).
- `triggered` in 1: trigger condition met (trigger stage output).
- `arm` in 1: one-cycle pulse; starts a capture.
- `abort` in 1: one-cycle pulse; cancels a capture.
- `force_trig` in 1: level; software trigger, ORed with `triggered`.
- `npre` in AW: number of pre-trigger samples.
- `npost` in AW: number of post-trigger samples, excluding the trigger sample.
- `div` in DW: take one sample every `div`+1 clocks.
- `wr_en` out 1: RAM write strobe, registered.
- `wr_addr` out AW: RAM write address, registered.
- `wr_data` out NSIG: RAM write data, registered.
- `trig_addr` out AW: RAM address of the trigger sample.
- `busy` out 1: high in PRE, WAIT and POST.
- `done` out 1: high in DONE.
- `state` out 3: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.

## Operation

- **Reset values:** `state`=IDLE; `wr_en`, `busy` and `done` are 0; `wr_addr`, `wr_data` and `trig_addr` are 0. All internal counters are 0.
- **Sample strobe (`stb`):** the prescaler counts 0..`div` and wraps to 0. `stb`=1 when the count is 0. The count clears to 0 on the arm transition, so the first PRE cycle is always a strobe. With `div`=0, every cycle is a strobe. `div` is sampled on arm; changing it mid-capture has no effect.
- **Write rule:** in PRE, WAIT and POST, each strobe registers `wr_en`=1 and `wr_data`=`sig`. The address is incremented after each write, modulo 2^AW (it wraps silently). No writes occur in IDLE or DONE.
- **Trigger qualification:** `trig` = `triggered` | `force_trig`. It is evaluated only on strobe cycles in WAIT; triggers in PRE or between strobes are ignored.
- **IDLE / DONE + `arm`:**
  - Go to PRE; clear the address pointer, the counters and `done`.
  - If `npre`=0, go directly to WAIT.
  - `npre`, `npost` and `div` are latched at this point.
- **PRE:** count strobes. After the `npre`-th write, go to WAIT.
- **WAIT:**
  - Write on each strobe.
  - On a strobe with `trig`=1, that sample is the trigger sample: latch `trig_addr` = its address.
  - Then go to POST, or to DONE if `npost`=0.
- **POST:** after `npost` further strobe writes, go to DONE.
- **DONE:** `done`=1 and `busy`=0. `trig_addr` holds until the next arm.
- **`abort`:** from any state, go to IDLE on the next edge. The write of that cycle is suppressed. `trig_addr` is left unchanged.
- **Simultaneous `arm` and `abort`:** abort wins.
- **`arm` while `busy`:** ignored.
- **Buffer overrun:** if `npre`+`npost`+1 > 2^AW, the oldest samples are overwritten. This is not an error; the host must use `trig_addr` to locate data.

## Timing

- **Write latency:** `sig` and `trig` are sampled at edge n, and the corresponding `wr_en`/`wr_addr`/`wr_data` are valid after edge n+1. End-to-end latency from the pin is therefore the trigger stage latency plus 1.
- **State transitions:** `state` changes on the edge that performs the last write of a phase. `done` asserts in the same cycle that `wr_en` shows the final write.
- **Arm response:** `arm` at edge n puts `busy`=1 after n+1, and the first `wr_en` appears after n+2.
- **Capture length:** a completed capture with no abort issues exactly `npre` + (WAIT writes) + 1 + `npost` writes.

## Test plan

- **Basic capture:** `div`=0, `npre`=4, `npost`=3, `triggered` pulsed on the 7th strobe. Expect 4 PRE writes at addresses 0–3, WAIT writes at 4–5, the trigger sample at addr 6 with `trig_addr`=6, POST writes at 7–9, then DONE. That is 10 writes in total with `wr_data` matching delayed `sig`.
- **Early trigger ignored:** `triggered` held high from arm with `npre`=2. Expect the trigger sample at addr 2 (the first WAIT strobe), not earlier.
- **Decimation:** `div`=2, `npre`=1, `npost`=1, `force_trig`=1. Expect exactly 3 writes spaced 3 clocks apart, then `done`=1.
- **Zero counts and wrap:** `npre`=0 and `npost`=0 goes straight to WAIT and gives a single write at addr 0. Separately, with AW=3 and 10 WAIT strobes before the trigger, expect `wr_addr` to wrap 7→0 and `trig_addr`=2.
- **Abort:** abort in POST → IDLE next cycle, no further `wr_en`, `done`=0. Asserting `arm` and `abort` together from IDLE leaves the block in IDLE.
- **Reset mid-capture:** assert `reset` asynchronously in WAIT, between clock edges. All outputs return to reset values immediately; after release, a subsequent `arm` capture behaves as in the basic capture test.
